// File: rtl/song_draw_sequencer.sv
// rtl/song_draw_sequencer.sv - control FSM that clears the play area and redraws the scrolling note grid
// Strobes are decoded from state; plot is each path's pixel-valid delayed to match datapath latency.
module song_draw_sequencer #(
    parameter int GRID_W           = 240,
    parameter int GRID_H           = 180,
    parameter int BOX_W            = 30,
    parameter int BOX_H            = 60,
    parameter int NUM_BOXES        = 12,
    parameter int SONG_LEN         = 112,
    parameter int FRAMES_PER_SHIFT = 4,
    parameter int DRAW_LAT         = 3,
    parameter int CLR_LAT          = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        frameTick,
    output logic        shiftSong,
    output logic        loadStartAddress,
    output logic        loadX,
    output logic        loadY,
    output logic        writeToScreen,
    output logic        loadDefault,
    output logic        writeDefault,
    output logic        songDone,
    output logic [15:0] gridCounter,
    output logic [3:0]  boxCounter,
    output logic [14:0] pixelCount,
    output logic        plot,
    output logic        busy
);

    localparam int TW = $clog2(FRAMES_PER_SHIFT + 2);
    localparam int SW = $clog2(SONG_LEN + 1);
    localparam int LW = $clog2((DRAW_LAT > CLR_LAT ? DRAW_LAT : CLR_LAT) + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_CLR_DRAIN, S_WAIT, S_SHIFT,
        S_BOX_SETUP, S_DRAW, S_DRAW_DRAIN, S_CHECK, S_DONE
    } state_t;

    state_t state, next_state;

    logic [7:0]          grid_x, grid_y;
    logic [7:0]          pix_x;
    logic [6:0]          pix_y;
    logic [3:0]          box;
    logic [TW-1:0]       tick_count, tick_total;
    logic [SW-1:0]       shift_count;
    logic [LW-1:0]       drain_cnt;
    logic                setup_cnt;
    logic                pending;
    logic [CLR_LAT-1:0]  clr_pipe;
    logic [DRAW_LAT-1:0] draw_pipe;
    logic                grid_last, pix_last, wait_entry;

    assign grid_last  = (grid_x == 8'(GRID_W - 1)) && (grid_y == 8'(GRID_H - 1));
    assign pix_last   = (pix_x == 8'(BOX_W - 1)) && (pix_y == 7'(BOX_H - 1));
    assign tick_total = tick_count + TW'(frameTick);
    assign wait_entry = (state != S_WAIT) && (next_state == S_WAIT);

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:       if (start) next_state = S_CLEAR;
            S_CLEAR:      if (grid_last) next_state = S_CLR_DRAIN;
            S_CLR_DRAIN:  if (drain_cnt == LW'(CLR_LAT - 1)) next_state = S_WAIT;
            S_WAIT:       if (tick_total >= TW'(FRAMES_PER_SHIFT)) next_state = S_SHIFT;
            S_SHIFT:      next_state = S_BOX_SETUP;
            S_BOX_SETUP:  if (setup_cnt) next_state = S_DRAW;
            S_DRAW:       if (pix_last) next_state = S_DRAW_DRAIN;
            S_DRAW_DRAIN: begin
                if (drain_cnt == LW'(DRAW_LAT - 1))
                    next_state = (box == 4'(NUM_BOXES)) ? S_CHECK : S_BOX_SETUP;
            end
            S_CHECK:      next_state = (shift_count == SW'(SONG_LEN)) ? S_DONE : S_WAIT;
            S_DONE:       next_state = S_IDLE;
            default:      next_state = S_IDLE;
        endcase
    end

    always_comb begin
        shiftSong        = 1'b0;
        loadStartAddress = 1'b0;
        loadX            = 1'b0;
        loadY            = 1'b0;
        writeToScreen    = 1'b0;
        loadDefault      = 1'b0;
        writeDefault     = 1'b0;
        songDone         = 1'b0;
        case (state)
            S_CLEAR, S_CLR_DRAIN: begin
                loadDefault  = 1'b1;
                writeDefault = 1'b1;
            end
            S_SHIFT:     shiftSong = 1'b1;
            S_BOX_SETUP: loadStartAddress = ~setup_cnt;
            S_DRAW, S_DRAW_DRAIN: begin
                loadX         = 1'b1;
                loadY         = 1'b1;
                writeToScreen = 1'b1;
            end
            S_DONE:      songDone = 1'b1;
            default: ;
        endcase
    end

    assign busy        = (state != S_IDLE);
    assign plot        = clr_pipe[CLR_LAT-1] | draw_pipe[DRAW_LAT-1];
    assign gridCounter = {grid_x, grid_y};
    assign boxCounter  = box;
    assign pixelCount  = {pix_x, pix_y};

    always_ff @(posedge clock) begin
        if (reset) begin
            grid_x      <= '0;
            grid_y      <= '0;
            pix_x       <= '0;
            pix_y       <= '0;
            box         <= '0;
            shift_count <= '0;
            drain_cnt   <= '0;
            setup_cnt   <= 1'b0;
            clr_pipe    <= '0;
            draw_pipe   <= '0;
        end else begin
            clr_pipe  <= (clr_pipe << 1) | CLR_LAT'(state == S_CLEAR);
            draw_pipe <= (draw_pipe << 1) | DRAW_LAT'(state == S_DRAW);
            drain_cnt <= ((state == S_CLR_DRAIN || state == S_DRAW_DRAIN) && next_state == state)
                         ? drain_cnt + LW'(1) : '0;
            setup_cnt <= (state == S_BOX_SETUP) ? ~setup_cnt : 1'b0;
            case (state)
                S_IDLE: begin
                    grid_x <= '0;
                    grid_y <= '0;
                end
                S_CLEAR: begin
                    // Hold on the last pixel so the drain still shows the final address
                    if (!grid_last) begin
                        if (grid_y == 8'(GRID_H - 1)) begin
                            grid_y <= '0;
                            grid_x <= grid_x + 8'd1;
                        end else begin
                            grid_y <= grid_y + 8'd1;
                        end
                    end
                end
                S_CLR_DRAIN: begin
                    if (next_state != S_CLR_DRAIN) begin
                        grid_x <= '0;
                        grid_y <= '0;
                    end
                end
                S_SHIFT: begin
                    shift_count <= shift_count + SW'(1);
                    box         <= 4'd1;
                end
                S_BOX_SETUP: begin
                    pix_x <= '0;
                    pix_y <= '0;
                end
                S_DRAW: begin
                    if (!pix_last) begin
                        if (pix_y == 7'(BOX_H - 1)) begin
                            pix_y <= '0;
                            pix_x <= pix_x + 8'd1;
                        end else begin
                            pix_y <= pix_y + 7'd1;
                        end
                    end
                end
                S_DRAW_DRAIN: if (next_state == S_BOX_SETUP) box <= box + 4'd1;
                S_CHECK: begin
                    box   <= '0;
                    pix_x <= '0;
                    pix_y <= '0;
                end
                S_DONE:  shift_count <= '0;
                default: ;
            endcase
        end
    end

    // One tick of credit survives the busy phases; it is folded in as WAIT is entered
    always_ff @(posedge clock) begin
        if (reset) begin
            tick_count <= '0;
            pending    <= 1'b0;
        end else if (wait_entry) begin
            tick_count <= (pending | frameTick) ? TW'(1) : '0;
            pending    <= 1'b0;
        end else if (state == S_WAIT) begin
            tick_count <= (tick_total >= TW'(FRAMES_PER_SHIFT)) ? '0 : tick_total;
        end else if (state == S_IDLE) begin
            tick_count <= '0;
            pending    <= 1'b0;
        end else if (frameTick) begin
            pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_song_draw_sequencer.sv
// tb/tb_song_draw_sequencer.sv - directed self-checking bench for song_draw_sequencer
// Full-size instance for clear/draw/pending/reset; a shrunken short-song instance for end of song.
module tb_song_draw_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start_a = 1'b0, tick_a = 1'b0;
    logic start_b = 1'b0, tick_b = 1'b0;

    always #5 clock = ~clock;

    logic        shift_a, lsa_a, lx_a, ly_a, wts_a, ldef_a, wdef_a, done_a, plot_a, busy_a;
    logic [15:0] grid_a;
    logic [3:0]  box_a;
    logic [14:0] pix_a;

    logic        shift_b, lsa_b, lx_b, ly_b, wts_b, ldef_b, wdef_b, done_b, plot_b, busy_b;
    logic [15:0] grid_b;
    logic [3:0]  box_b;
    logic [14:0] pix_b;

    song_draw_sequencer dut_a (
        .clock(clock), .reset(reset), .start(start_a), .frameTick(tick_a),
        .shiftSong(shift_a), .loadStartAddress(lsa_a), .loadX(lx_a), .loadY(ly_a),
        .writeToScreen(wts_a), .loadDefault(ldef_a), .writeDefault(wdef_a),
        .songDone(done_a), .gridCounter(grid_a), .boxCounter(box_a),
        .pixelCount(pix_a), .plot(plot_a), .busy(busy_a)
    );

    song_draw_sequencer #(
        .GRID_W(8), .GRID_H(6), .BOX_W(3), .BOX_H(4),
        .SONG_LEN(2), .FRAMES_PER_SHIFT(1)
    ) dut_b (
        .clock(clock), .reset(reset), .start(start_b), .frameTick(tick_b),
        .shiftSong(shift_b), .loadStartAddress(lsa_b), .loadX(lx_b), .loadY(ly_b),
        .writeToScreen(wts_b), .loadDefault(ldef_b), .writeDefault(wdef_b),
        .songDone(done_b), .gridCounter(grid_b), .boxCounter(box_b),
        .pixelCount(pix_b), .plot(plot_b), .busy(busy_b)
    );

    logic [44:0] outs_a;
    assign outs_a = {shift_a, lsa_a, lx_a, ly_a, wts_a, ldef_a, wdef_a, done_a,
                     grid_a, box_a, pix_a, plot_a, busy_a};

    int checks = 0;
    int passed = 0;

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (outs_a !== 45'd0) $display("FAIL reset_outputs: got %h want 0", outs_a);
        else passed++;
        reset = 1'b0;
    endtask

    task automatic test_clear();
        int i, plots, first_plot, model_err, excl;
        logic [15:0] exp, last_grid;
        repeat (4) @(negedge clock);
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1) $display("FAIL clear_busy: got %b want 1", busy_a);
        else passed++;
        checks++;
        if (grid_a !== 16'h0000) $display("FAIL clear_first_grid: got %h want 0000", grid_a);
        else passed++;
        i = 0; plots = 0; first_plot = -1; model_err = 0; excl = 0; last_grid = '0;
        while (wdef_a && i < 50000) begin
            if (i < 43200) begin
                exp = {8'(i / 180), 8'(i % 180)};
                if (grid_a !== exp) model_err++;
            end
            if (plot_a) begin
                if (first_plot < 0) first_plot = i;
                plots++;
            end
            if (wts_a || ldef_a !== 1'b1) excl++;
            last_grid = grid_a;
            start_a = (i == 1000);
            @(negedge clock);
            i++;
        end
        start_a = 1'b0;
        checks++;
        if (model_err != 0) $display("FAIL clear_walk: errors=%0d want 0", model_err);
        else passed++;
        checks++;
        if (plots != 43200) $display("FAIL clear_plots: got %0d want 43200", plots);
        else passed++;
        checks++;
        if (first_plot != 2) $display("FAIL clear_first_plot: got %0d want 2", first_plot);
        else passed++;
        checks++;
        if (last_grid !== 16'hEFB3) $display("FAIL clear_last_grid: got %h want efb3", last_grid);
        else passed++;
        checks++;
        if (i != 43202) $display("FAIL clear_length: got %0d want 43202", i);
        else passed++;
        checks++;
        if (excl != 0) $display("FAIL clear_strobes: errors=%0d want 0", excl);
        else passed++;
    endtask

    task automatic test_shift();
        int early, plots, box_err, lsa_err, wts_err, pix_err, plot_err, excl, n;
        logic [14:0] exp;
        early = 0;
        repeat (3) begin
            tick_a = 1'b1;
            @(negedge clock);
            tick_a = 1'b0;
            if (shift_a) early++;
            repeat (2) begin
                @(negedge clock);
                if (shift_a || box_a !== 4'd0) early++;
            end
        end
        checks++;
        if (early != 0) $display("FAIL shift_early: got %0d want 0", early);
        else passed++;
        tick_a = 1'b1;
        @(negedge clock);
        tick_a = 1'b0;
        checks++;
        if (shift_a !== 1'b1) $display("FAIL shift_pulse: got %b want 1", shift_a);
        else passed++;
        plots = 0; box_err = 0; lsa_err = 0; wts_err = 0; pix_err = 0; plot_err = 0; excl = 0;
        for (int b = 1; b <= 12; b++) begin
            for (int r = 0; r < 1805; r++) begin
                @(negedge clock);
                tick_a = ((b == 3 && r == 500) || (b == 7 && r == 100));
                if (box_a !== 4'(b)) box_err++;
                if (lsa_a !== (r == 0)) lsa_err++;
                if (wts_a !== (r >= 2) || lx_a !== (r >= 2) || ly_a !== (r >= 2)) wts_err++;
                if (r >= 2) begin
                    n = (r - 2 < 1800) ? r - 2 : 1799;
                    exp = {8'(n / 60), 7'(n % 60)};
                    if (pix_a !== exp) pix_err++;
                end
                if (plot_a !== (r >= 5)) plot_err++;
                if (plot_a) plots++;
                if (shift_a || (wdef_a && wts_a)) excl++;
            end
        end
        tick_a = 1'b0;
        checks++;
        if (box_err != 0) $display("FAIL draw_box_counter: errors=%0d want 0", box_err);
        else passed++;
        checks++;
        if (lsa_err != 0) $display("FAIL draw_load_start: errors=%0d want 0", lsa_err);
        else passed++;
        checks++;
        if (wts_err != 0) $display("FAIL draw_write_strobes: errors=%0d want 0", wts_err);
        else passed++;
        checks++;
        if (pix_err != 0) $display("FAIL draw_pixel_walk: errors=%0d want 0", pix_err);
        else passed++;
        checks++;
        if (plot_err != 0) $display("FAIL draw_plot_align: errors=%0d want 0", plot_err);
        else passed++;
        checks++;
        if (plots != 21600) $display("FAIL draw_plots: got %0d want 21600", plots);
        else passed++;
        checks++;
        if (excl != 0) $display("FAIL draw_exclusive: errors=%0d want 0", excl);
        else passed++;
        repeat (2) @(negedge clock);
        checks++;
        if ({busy_a, wts_a, shift_a, box_a} !== {1'b1, 1'b0, 1'b0, 4'd0})
            $display("FAIL draw_back_to_wait: got %b want 1000000", {busy_a, wts_a, shift_a, box_a});
        else passed++;
    endtask

    task automatic test_pending();
        int early, shifts;
        logic first_ok;
        early = 0;
        repeat (2) begin
            tick_a = 1'b1;
            @(negedge clock);
            tick_a = 1'b0;
            if (shift_a) early++;
            repeat (2) begin
                @(negedge clock);
                if (shift_a) early++;
            end
        end
        checks++;
        if (early != 0) $display("FAIL pending_early_shift: got %0d want 0", early);
        else passed++;
        tick_a = 1'b1;
        @(negedge clock);
        tick_a = 1'b0;
        first_ok = shift_a;
        shifts = shift_a ? 1 : 0;
        repeat (3) begin
            @(negedge clock);
            if (shift_a) shifts++;
        end
        checks++;
        if (!(first_ok && shifts == 1))
            $display("FAIL pending_shift: got prompt=%b pulses=%0d want prompt=1 pulses=1", first_ok, shifts);
        else passed++;
    endtask

    task automatic test_mid_reset();
        int k, bad;
        k = 0;
        while (!(box_a == 4'd5 && pix_a == 15'h0780 && wts_a) && k < 12000) begin
            @(negedge clock);
            k++;
        end
        checks++;
        if (k >= 12000) $display("FAIL reset_reach_box5: timeout after %0d cycles", k);
        else passed++;
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (outs_a !== 45'd0) $display("FAIL reset_mid_draw: got %h want 0", outs_a);
        else passed++;
        reset = 1'b0;
        bad = 0;
        repeat (10) begin
            @(negedge clock);
            if (plot_a || busy_a) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL reset_quiet: errors=%0d want 0", bad);
        else passed++;
        start_a = 1'b1;
        @(negedge clock);
        start_a = 1'b0;
        checks++;
        if ({busy_a, wdef_a, grid_a} !== {1'b1, 1'b1, 16'h0000})
            $display("FAIL restart_clear: got %h want 30000", {busy_a, wdef_a, grid_a});
        else passed++;
        @(negedge clock);
        checks++;
        if (grid_a !== 16'h0001) $display("FAIL restart_step: got %h want 0001", grid_a);
        else passed++;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_song_end();
        int i, plots, shifts, dones, done_i, last_plot;
        logic finished, idle_after;
        start_b = 1'b1;
        @(negedge clock);
        start_b = 1'b0;
        tick_b = 1'b1;
        i = 0; plots = 0; shifts = 0; dones = 0; done_i = -1; last_plot = -1;
        finished = 1'b0; idle_after = 1'b0;
        while (i < 3000 && !finished) begin
            if (done_i >= 0 && i == done_i + 1) begin
                idle_after = !busy_b;
                finished = 1'b1;
            end else begin
                if (plot_b) begin
                    plots++;
                    last_plot = i;
                end
                if (shift_b) shifts++;
                if (done_b) begin
                    dones++;
                    done_i = i;
                end
                @(negedge clock);
                i++;
            end
        end
        tick_b = 1'b0;
        checks++;
        if (shifts != 2) $display("FAIL song_shifts: got %0d want 2", shifts);
        else passed++;
        checks++;
        if (dones != 1) $display("FAIL song_done_pulses: got %0d want 1", dones);
        else passed++;
        checks++;
        if (done_i - last_plot != 2) $display("FAIL song_done_timing: got %0d want 2", done_i - last_plot);
        else passed++;
        checks++;
        if (idle_after !== 1'b1) $display("FAIL song_idle_after: got %b want 1", idle_after);
        else passed++;
        checks++;
        if (plots != 336) $display("FAIL song_plots: got %0d want 336", plots);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_clear();
        test_shift();
        test_pending();
        test_mid_reset();
        test_song_end();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/song_draw_sequencer.md
Name: song_draw_sequencer

Overview:
- Control FSM for the note-grid datapath. Clears the 240x180 play area on start, then on every FRAMES_PER_SHIFT frame ticks shifts the song one step and redraws the 12 note boxes (4 columns x 3 rows, 30x60 px each).
- Generates every strobe and counter the datapath consumes, plus a `plot` write-enable for the VGA adapter, aligned to the datapath's registered outputs.
- After SONG_LEN shifts it pulses songDone and returns to idle.

Parameters:
- GRID_W, 240, clear-area width in px.
- GRID_H, 180, clear-area height in px.
- BOX_W, 30, note box width in px.
- BOX_H, 60, note box height in px.
- NUM_BOXES, 12, boxes redrawn per step; boxCounter runs 1..NUM_BOXES.
- SONG_LEN, 112, shifts per song.
- FRAMES_PER_SHIFT, 4, frameTick pulses per song shift.
- DRAW_LAT, 3, cycles from pixelCount issue to datapath VGA outputs valid.
- CLR_LAT, 2, cycles from gridCounter issue to VGA outputs valid.

Ports:
- clock, in, 1, system clock.
- reset, in, 1, synchronous, active-high.
- start, in, 1, one-cycle request to begin a song; honoured only in IDLE.
- frameTick, in, 1, one-cycle pulse per video frame.
- shiftSong, out, 1, one-cycle shift/sample of the note registers.
- loadStartAddress, out, 1, high for the first cycle after boxCounter changes.
- loadX, out, 1, address/XY register load; asserted with loadY.
- loadY, out, 1, see loadX.
- writeToScreen, out, 1, selects box pixel path into VGA output regs.
- loadDefault, out, 1, loads clear-pixel register.
- writeDefault, out, 1, selects clear path.
- songDone, out, 1, one-cycle end-of-song pulse.
- gridCounter, out, 16, {x[7:0], y[7:0]} of the clear pixel.
- boxCounter, out, 4, current box 1..12; 0 when not drawing.
- pixelCount, out, 15, {x[7:0], y[6:0]} within the box.
- plot, out, 1, VGA write enable.
- busy, out, 1, high in any state except IDLE.

Behaviour:
- Reset: state IDLE. All outputs 0. All counters, pending flag and pipelines cleared. Reset mid-operation aborts immediately; no further plot is issued.
- IDLE -> CLEAR on start.
- CLEAR:
  - gridCounter walks y 0..GRID_H-1 inner, x 0..GRID_W-1 outer, one step per cycle.
  - loadDefault and writeDefault are high throughout CLEAR and CLR_DRAIN.
  - plot is the CLEAR pixel-valid delayed by CLR_LAT cycles, giving exactly 43200 plots.
  - After the last pixel, CLR_DRAIN lasts CLR_LAT cycles, then WAIT.
- WAIT:
  - Counts frameTicks. When FRAMES_PER_SHIFT ticks are reached (tick counter wraps to 0), go to SHIFT.
  - frameTick arriving outside WAIT sets a single pending flag, consumed on WAIT entry. A second tick while pending is dropped.
- SHIFT: shiftSong high for exactly 1 cycle; shift count increments; go to BOX_SETUP with boxCounter=1.
- BOX_SETUP:
  - 2 cycles, loadStartAddress high in the first cycle.
  - Covers the datapath's registered colour and start-address latency.
- DRAW:
  - pixelCount walks y 0..BOX_H-1 inner, x 0..BOX_W-1 outer (1800 cycles per box).
  - loadX=loadY=1 and writeToScreen=1 in DRAW and DRAW_DRAIN.
  - plot is the DRAW pixel-valid delayed by DRAW_LAT.
  - DRAW_DRAIN lasts DRAW_LAT cycles; boxCounter must not change before the drain ends.
  - Then boxCounter+1 -> BOX_SETUP, or after box NUM_BOXES go to CHECK.
- CHECK: if shift count == SONG_LEN, go to DONE; else boxCounter=0 and go to WAIT.
- DONE: songDone high for 1 cycle; shift count cleared; go to IDLE.
- Output exclusivity: writeDefault and writeToScreen are never high together. shiftSong is never high while loadX is high.
- Counter widths: x fields never exceed 239 (clear) / 29 (box); y fields never exceed 179 / 59. Unused MSBs are 0.
- start while busy is ignored.

Test Plan:
- Reset, start at cycle 5 -> busy=1 next cycle; 43200 plot pulses with writeDefault=1; first plot 2 cycles after first gridCounter=0x0000; last gridCounter=0xEFB3.
- After clear, 4 frameTicks -> exactly one shiftSong pulse; boxCounter sequences 1..12; 1800 plots per box; first box plot 3 cycles after pixelCount=0; last pixelCount per box=0x0EBB.
- frameTick during DRAW, plus a second tick during the same DRAW -> exactly one pending tick credited; next shift after 3 further ticks.
- Run with SONG_LEN=2, FRAMES_PER_SHIFT=1 -> 2 shiftSong pulses, songDone one cycle after box 12 drains on the 2nd pass, then busy=0.
- Assert reset mid-DRAW (box 5, pixel 900) -> next cycle all outputs 0, no plot, state IDLE; subsequent start re-clears from gridCounter=0.
- start pulsed while busy -> no effect on counters or sequence.
